// File: rtl/riscv_writeback_unit.sv
// Register-file write-port arbiter: merges ALU results with queued load responses,
// formats load data by width/sign, suppresses x0 writes and exports pending-load registers.
module riscv_writeback_unit #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid_i,
  input  logic [4:0]               alu_rd_i,
  input  logic [31:0]              alu_result_i,
  output logic                     alu_stall_o,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [4:0]               ld_rd_i,
  input  logic [2:0]               ld_funct3_i,
  input  logic [1:0]               ld_addr_lo_i,
  input  logic [31:0]              ld_rdata_i,
  output logic                     wb_we_o,
  output logic [4:0]               wb_addr_o,
  output logic [31:0]              wb_data_o,
  output logic [31:0]              pend_mask_o,
  output logic [$clog2(DEPTH):0]   ld_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    entRd_q   [DEPTH];
  logic [2:0]    entF3_q   [DEPTH];
  logic [1:0]    entLo_q   [DEPTH];
  logic [31:0]   entData_q [DEPTH];
  logic [DEPTH-1:0] entVld_q;

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] age_q, age_d;
  logic          wbWe_q, wbWe_d;
  logic [4:0]    wbAddr_q, wbAddr_d;
  logic [31:0]   wbData_q, wbData_d;

  logic          fifoEmpty, pushEn, popEn, aluWrite;
  logic [4:0]    headRd;
  logic [2:0]    headF3;
  logic [1:0]    headLo;
  logic [31:0]   headData, fmtData;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;

  assign fifoEmpty   = (count_q == '0);
  assign ld_ready_o  = (count_q < CW'(DEPTH));
  assign alu_stall_o = (age_q == AW'(STARVE_LIMIT)) && !fifoEmpty;
  assign pushEn      = ld_valid_i && ld_ready_o;
  assign aluWrite    = !alu_stall_o && alu_valid_i && (alu_rd_i != 5'd0);
  // An rd==0 ALU result is consumed silently, so it leaves the port free for a pop.
  assign popEn       = !fifoEmpty && !aluWrite;

  assign headRd   = entRd_q[head_q];
  assign headF3   = entF3_q[head_q];
  assign headLo   = entLo_q[head_q];
  assign headData = entData_q[head_q];

  assign wb_we_o    = wbWe_q;
  assign wb_addr_o  = wbAddr_q;
  assign wb_data_o  = wbData_q;
  assign ld_count_o = count_q;

  always_comb begin
    byteSel = 8'(headData >> {headLo, 3'b000});
    halfSel = 16'(headData >> {headLo[1], 4'b0000});
    case (headF3)
      3'b000:  fmtData = {{24{byteSel[7]}}, byteSel};
      3'b001:  fmtData = {{16{halfSel[15]}}, halfSel};
      3'b100:  fmtData = {24'd0, byteSel};
      3'b101:  fmtData = {16'd0, halfSel};
      default: fmtData = headData;
    endcase
  end

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entVld_q[i]) pend_mask_o[entRd_q[i]] = 1'b1;
    end
    pend_mask_o[0] = 1'b0;
  end

  always_comb begin
    wbWe_d   = 1'b0;
    wbAddr_d = wbAddr_q;
    wbData_d = wbData_q;
    if (aluWrite) begin
      wbWe_d   = 1'b1;
      wbAddr_d = alu_rd_i;
      wbData_d = alu_result_i;
    end else if (popEn && (headRd != 5'd0)) begin
      wbWe_d   = 1'b1;
      wbAddr_d = headRd;
      wbData_d = fmtData;
    end

    count_d = count_q + CW'(pushEn) - CW'(popEn);

    // The age counter measures how long the current head has waited.
    if (popEn || fifoEmpty)                 age_d = '0;
    else if (age_q != AW'(STARVE_LIMIT))    age_d = age_q + AW'(1);
    else                                    age_d = age_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      age_q    <= '0;
      entVld_q <= '0;
      wbWe_q   <= 1'b0;
      wbAddr_q <= '0;
      wbData_q <= '0;
    end else begin
      count_q  <= count_d;
      age_q    <= age_d;
      wbWe_q   <= wbWe_d;
      wbAddr_q <= wbAddr_d;
      wbData_q <= wbData_d;
      if (popEn) begin
        entVld_q[head_q] <= 1'b0;
        head_q           <= head_q + PW'(1);
      end
      if (pushEn) begin
        entVld_q[tail_q] <= 1'b1;
        tail_q           <= tail_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) begin
      entRd_q[tail_q]   <= ld_rd_i;
      entF3_q[tail_q]   <= ld_funct3_i;
      entLo_q[tail_q]   <= ld_addr_lo_i;
      entData_q[tail_q] <= ld_rdata_i;
    end
  end

endmodule

// File: doc/riscv_writeback_unit.md
Name: riscv_writeback_unit

Overview:
- Write-side initiator for the core's 32x32 register file. It merges ALU results and memory load responses into the register file's single write port (address, data, write enable).
- It buffers load responses in a small FIFO and formats load data by width and sign.
- It suppresses all writes to x0.
- It exports a pending-destination mask so decode can stall on registers with queued loads.

Parameters:
- DEPTH, 4, load FIFO entries (power of two, at least 2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before the load path takes priority over the ALU

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_result  in  32  ALU result data
- alu_stall  out  1  ALU result not accepted this cycle; upstream holds alu_valid, alu_rd and alu_result
- ld_valid  in  1  load response valid
- ld_ready  out  1  FIFO can accept a load response
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type (RISC-V funct3 encoding)
- ld_addr_lo  in  2  byte offset of the load address
- ld_rdata  in  32  raw aligned 32-bit memory word
- wb_we  out  1  register file write enable
- wb_addr  out  5  register file write address
- wb_data  out  32  register file write data
- pend_mask  out  32  bit r is 1 while any queued load targets xr; bit 0 is always 0
- ld_count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, applied asynchronously:
  - wb_we=0, wb_addr=0, wb_data=0.
  - FIFO empty, ld_count=0, pend_mask=0.
  - Age counter=0, alu_stall=0.
  - ld_ready=1 once rst deasserts.
  - Reset mid-operation discards all queued loads; no write is issued after reset.
- Load enqueue:
  - ld_ready = (ld_count < DEPTH), based on the registered count only.
  - A pop in the same cycle does not raise ld_ready.
  - A handshake (ld_valid && ld_ready) pushes {rd, funct3, addr_lo, rdata} at the clock edge.
- Age counter:
  - Cleared on every pop and whenever the FIFO is empty.
  - Otherwise increments each cycle the FIFO is non-empty, saturating at STARVE_LIMIT.
- alu_stall: combinational; equals (age == STARVE_LIMIT) && FIFO non-empty.
- Write-port selection, evaluated each cycle, highest priority first:
  - (1) alu_stall=1: pop the head.
  - (2) alu_valid && alu_rd!=0: write the ALU result.
  - (3) FIFO non-empty: pop the head.
  - (4) Otherwise: no write.
- ALU results with alu_rd==0 while not stalled are consumed with no write, and the FIFO head may pop in that same cycle.
- A popped head with rd==0 is discarded: it pops, but wb_we stays 0 for it.
- Output registers:
  - The selected write appears on wb_we/wb_addr/wb_data at the next rising edge, for exactly one cycle.
  - wb_we=0 when nothing is selected; wb_addr/wb_data hold their last values.
- Latency:
  - ALU: 1 cycle from acceptance to wb_we.
  - Load: at least 2 cycles from handshake to wb_we (push edge, then pop edge). Same-cycle bypass of an empty FIFO is not allowed.
- Load formatting, applied at pop on the head entry:
  - 000 LB: sign-extend byte addr_lo.
  - 001 LH: sign-extend halfword addr_lo[1]; addr_lo[0] ignored.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte addr_lo.
  - 101 LHU: zero-extend halfword addr_lo[1].
  - Any other encoding: full word.
- pend_mask: combinational OR of the decoded rd of all valid entries, excluding x0. A bit clears in the cycle after the entry's pop edge.
- Ordering:
  - Loads leave in FIFO order.
  - When an ALU write and a queued load target the same rd, the write order is the selection order; resolving the hazard is decode's job via pend_mask.
- Simultaneous events:
  - Push and pop in the same cycle: ld_count unchanged; head/tail pointers wrap modulo DEPTH.
  - Push while full is impossible because ld_ready=0.

Test Plan:
- Reset with FIFO holding 2 entries, then assert rst mid-cycle -> wb_we=0 immediately; after release ld_count=0, pend_mask=0, ld_ready=1, and no write occurs.
- ALU only: alu_valid=1, rd=5, result=0xDEADBEEF -> next cycle wb_we=1, wb_addr=5, wb_data=0xDEADBEEF; with rd=0 -> wb_we=0.
- Load formatting: rdata=0x80FF7F01 pushed four times:
  - LB addr_lo=3 -> 0xFFFFFF80
  - LBU addr_lo=1 -> 0x0000007F
  - LH addr_lo=2 -> 0xFFFF80FF
  - LHU addr_lo=0 -> 0x00007F01
  - Each write appears 2 cycles after its handshake when the ALU is idle.
- Fill the FIFO (DEPTH=4) with ld_rd=1..4 and no pops -> ld_ready=0 after the 4th push, pend_mask=0x0000001E; drain -> the bits clear in order 1,2,3,4.
- Starvation: alu_valid=1, rd=7 every cycle with one load queued -> after 8 waiting cycles alu_stall=1 for one cycle, the load writes, the held ALU result writes the following cycle, and alu_stall returns to 0.
- ALU write to x0 with a load queued (rd=9) -> the load pops that cycle; wb_addr=9 on the next edge.
